// File: rtl/frame_writer_small.sv
// frame_writer_small: captures one window of a 1-bit pixel raster into a
// frame buffer. A capture request arms the block; the window origin pixel
// starts the capture; every in-window pixel is written row-major through a
// two-stage address pipeline; the last window pixel ends the frame.
module frame_writer_small #(
  parameter int WIDTH    = 80,
  parameter int HEIGHT   = 107,
  parameter int H_ORIGIN = 0,
  parameter int V_ORIGIN = 0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        data_valid_in,
  input  logic        pixel_in,
  input  logic        capture_in,
  output logic        pixel_out,
  output logic [16:0] pixel_addr_out,
  output logic        write_enable_out,
  output logic        busy_out,
  output logic        done_out,
  output logic        short_out
);

  // Window bounds, one bit wider than the counters so origin+size never wraps.
  localparam logic [11:0] H_LO   = 12'(H_ORIGIN);
  localparam logic [11:0] H_HI   = 12'(H_ORIGIN + WIDTH);
  localparam logic [11:0] H_LAST = 12'(H_ORIGIN + WIDTH - 1);
  localparam logic [10:0] V_LO   = 11'(V_ORIGIN);
  localparam logic [10:0] V_HI   = 11'(V_ORIGIN + HEIGHT);
  localparam logic [10:0] V_LAST = 11'(V_ORIGIN + HEIGHT - 1);
  localparam logic [16:0] WIDTH_W      = 17'(WIDTH);
  localparam logic [17:0] FRAME_PIXELS = 18'(WIDTH * HEIGHT);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, FINISH} state_t;

  state_t      state_q, state_d;
  logic        drain_q, drain_d;
  logic [13:0] count_q, count_d;
  logic        done_q, done_d;
  logic        short_q, short_d;
  // stage 1
  logic [16:0] row_q, row_d;
  logic [16:0] col_q, col_d;
  logic        pix1_q, pix1_d;
  logic        win1_q, win1_d;
  // stage 2
  logic [16:0] addr_q, addr_d;
  logic        pix_q, pix_d;
  logic        we_q, we_d;

  logic [11:0] h_ext;
  logic [10:0] v_ext;
  logic [10:0] h_off;
  logic [9:0]  v_off;
  logic        at_origin;
  logic        at_last;
  logic        in_window;
  logic        capturing;

  // Window decode and offsets of the incoming pixel.
  always_comb begin
    h_ext     = {1'b0, hcount_in};
    v_ext     = {1'b0, vcount_in};
    h_off     = hcount_in - H_LO[10:0];
    v_off     = vcount_in - V_LO[9:0];
    at_origin = data_valid_in && (h_ext == H_LO) && (v_ext == V_LO);
    at_last   = (h_ext == H_LAST) && (v_ext == V_LAST);
    in_window = data_valid_in && (h_ext >= H_LO) && (h_ext < H_HI) &&
                (v_ext >= V_LO) && (v_ext < V_HI);
    // The origin pixel seen while armed is itself the first captured pixel.
    capturing = (state_q == CAPTURE) || ((state_q == ARMED) && at_origin);
  end

  // Next-state, pipeline and status logic.
  always_comb begin
    state_d = state_q;
    drain_d = 1'b0;
    done_d  = 1'b0;
    short_d = short_q;
    count_d = count_q + {13'b0, we_q};

    row_d  = 17'(v_off) * WIDTH_W;
    col_d  = 17'(h_off);
    pix1_d = pixel_in;
    win1_d = capturing && in_window;

    // Out-of-window cycles leave the write port's address and data untouched.
    we_d   = win1_q;
    addr_d = win1_q ? (row_q + col_q) : addr_q;
    pix_d  = win1_q ? pix1_q : pix_q;

    case (state_q)
      IDLE: begin
        if (capture_in) begin
          state_d = ARMED;
          count_d = '0;
        end
      end
      ARMED: begin
        if (at_origin) begin
          // A 1x1 window both starts and ends on the origin pixel.
          state_d = at_last ? FINISH : CAPTURE;
        end
      end
      CAPTURE: begin
        if (at_last) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        // Two cycles let the final pixel leave stage 2 before reporting.
        if (drain_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
          short_d = ({4'b0, count_d} < FRAME_PIXELS);
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pipeline and status registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      drain_q <= 1'b0;
      count_q <= '0;
      done_q  <= 1'b0;
      short_q <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      pix1_q  <= 1'b0;
      win1_q  <= 1'b0;
      addr_q  <= '0;
      pix_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      count_q <= count_d;
      done_q  <= done_d;
      short_q <= short_d;
      row_q   <= row_d;
      col_q   <= col_d;
      pix1_q  <= pix1_d;
      win1_q  <= win1_d;
      addr_q  <= addr_d;
      pix_q   <= pix_d;
      we_q    <= we_d;
    end
  end

  assign pixel_out        = pix_q;
  assign pixel_addr_out   = addr_q;
  assign write_enable_out = we_q;
  assign busy_out         = (state_q == ARMED) || (state_q == CAPTURE);
  assign done_out         = done_q;
  assign short_out        = short_q;

endmodule

// File: tb/tb_frame_writer_small.sv
// Scoreboard bench for frame_writer_small: the stimulus side pushes expected
// writes and done pulses (with their due cycle), and a negedge monitor pops
// and compares whatever the two DUT instances present.
module tb_frame_writer_small;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hc;
  logic [9:0]  vc;
  logic        valid, pix, cap_a, cap_b;

  logic        pix_a, we_a, busy_a, done_a, short_a;
  logic [16:0] addr_a;
  logic        pix_b, we_b, busy_b, done_b, short_b;
  logic [16:0] addr_b;

  always #5 clk = ~clk;

  frame_writer_small dut_a (
    .clk_in(clk), .rst_in(rst), .hcount_in(hc), .vcount_in(vc),
    .data_valid_in(valid), .pixel_in(pix), .capture_in(cap_a),
    .pixel_out(pix_a), .pixel_addr_out(addr_a), .write_enable_out(we_a),
    .busy_out(busy_a), .done_out(done_a), .short_out(short_a)
  );

  frame_writer_small #(.H_ORIGIN(100), .V_ORIGIN(20)) dut_b (
    .clk_in(clk), .rst_in(rst), .hcount_in(hc), .vcount_in(vc),
    .data_valid_in(valid), .pixel_in(pix), .capture_in(cap_b),
    .pixel_out(pix_b), .pixel_addr_out(addr_b), .write_enable_out(we_b),
    .busy_out(busy_b), .done_out(done_b), .short_out(short_b)
  );

  typedef struct {int addr; bit p; int c; int h; int v;} wr_t;
  typedef struct {int c; bit sh;} dn_t;

  wr_t q_a[$], q_b[$];
  dn_t dq_a[$], dq_b[$];
  int  total = 0, bad = 0;
  int  cyc = 0;
  int  last_drive_cyc = 0;
  bit  cap_active = 1'b0;
  int  wr_n[2], first_addr[2], last_addr[2], addr52[2], done_n[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit pix_of(input int h, input int v);
    return h[0] ^ v[0] ^ h[2];
  endfunction

  function automatic bit in_win(input int ho, input int vo, input int h, input int v);
    return (h >= ho) && (h < ho + 80) && (v >= vo) && (v < vo + 107);
  endfunction

  task automatic reset_stats(input int s);
    wr_n[s] = 0; done_n[s] = 0;
    first_addr[s] = -1; last_addr[s] = -1; addr52[s] = -1;
  endtask

  // Monitor for one instance: pop and compare each write / done pulse.
  task automatic mon(input int s, input logic we, input logic [16:0] addr,
                     input logic p, input logic dn, input logic sh);
    wr_t   e;
    dn_t   d;
    string pfx;
    int    qn, dqn;
    pfx = (s == 0) ? "a" : "b";
    qn  = (s == 0) ? q_a.size() : q_b.size();
    dqn = (s == 0) ? dq_a.size() : dq_b.size();
    if (we === 1'b1) begin
      if (qn == 0) begin
        check({pfx, "_spurious_write"}, 1, 0);
      end else begin
        if (s == 0) e = q_a.pop_front(); else e = q_b.pop_front();
        check({pfx, "_addr"}, int'(addr), e.addr);
        check({pfx, "_pixel"}, int'(p), int'(e.p));
        check({pfx, "_latency_cycle"}, cyc, e.c);
        wr_n[s]++;
        if (wr_n[s] == 1) first_addr[s] = int'(addr);
        last_addr[s] = int'(addr);
        if (e.h == 5 && e.v == 2) addr52[s] = int'(addr);
      end
    end
    if (dn === 1'b1) begin
      if (dqn == 0) begin
        check({pfx, "_spurious_done"}, 1, 0);
      end else begin
        if (s == 0) d = dq_a.pop_front(); else d = dq_b.pop_front();
        check({pfx, "_done_cycle"}, cyc, d.c);
        check({pfx, "_short"}, int'(sh), int'(d.sh));
        done_n[s]++;
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, we_a, addr_a, pix_a, done_a, short_a);
    mon(1, we_b, addr_b, pix_b, done_b, short_b);
  end

  // Drive one input cycle just after the rising edge; record expectation.
  task automatic drive(input bit s, input int h, input int v, input bit vld,
                       input bit p, input bit c);
    int  ho, vo;
    wr_t e;
    @(posedge clk);
    #1;
    ho = s ? 100 : 0;
    vo = s ? 20 : 0;
    hc = 11'(h); vc = 10'(v); valid = vld; pix = p;
    cap_a = (!s) && c;
    cap_b = s && c;
    last_drive_cyc = cyc;
    if (cap_active && vld && in_win(ho, vo, h, v)) begin
      e.addr = (v - vo) * 80 + (h - ho);
      e.p = p; e.c = cyc + 2; e.h = h - ho; e.v = v - vo;
      if (s) q_b.push_back(e); else q_a.push_back(e);
    end
  endtask

  // Arm, then raster the window; optional invalid pixels, extras, abort row.
  task automatic run_frame(input bit s, input int n_inv, input bit extras, input int abort_v);
    int  ho, vo;
    bit  vld;
    dn_t d;
    ho = s ? 100 : 0;
    vo = s ? 20 : 0;
    drive(s, ho + 1, vo + 1, 0, 0, 1);
    drive(s, ho + 1, vo, 1, 1, 0);       // armed, not the origin: ignored
    check(s ? "b_busy_armed" : "a_busy_armed", int'(s ? busy_b : busy_a), 1);
    drive(s, ho, vo, 0, 1, 0);           // origin but invalid: still armed
    cap_active = 1'b1;
    for (int v = vo; v < vo + 107; v++) begin
      for (int h = ho; h < ho + 80; h++) begin
        if (abort_v >= 0 && v == vo + abort_v && h == ho + 10) return;
        vld = !(n_inv > 0 && v == vo + 7 && h >= ho + 20 && h < ho + 20 + n_inv);
        drive(s, h, v, vld, pix_of(h, v), 0);
      end
      if (extras && v == vo + 3) begin
        drive(s, ho + 80, v, 1, 1, 1);   // capture request while capturing
        drive(s, 1023, v, 1, 0, 0);
        check(s ? "b_busy_capture" : "a_busy_capture", int'(s ? busy_b : busy_a), 1);
      end
      if (extras && v == vo + 5) begin
        drive(s, ho + 81, v, 1, 1, 0);
        drive(s, ho + 3, vo + 200, 1, 1, 0);
      end
      if (extras && v == vo + 10) begin
        drive(s, ho, vo, 1, pix_of(ho, vo), 0);  // second origin overwrites addr 0
      end
    end
    d.c = last_drive_cyc + 3;
    d.sh = (n_inv > 0);
    if (s) dq_b.push_back(d); else dq_a.push_back(d);
    cap_active = 1'b0;
    repeat (6) drive(s, 0, 0, 0, 0, 0);
  endtask

  task automatic frame_checks(input int s, input int exp_wr);
    string pfx;
    pfx = (s == 0) ? "a" : "b";
    check({pfx, "_write_count"}, wr_n[s], exp_wr);
    check({pfx, "_first_addr"}, first_addr[s], 0);
    check({pfx, "_last_addr"}, last_addr[s], 8559);
    check({pfx, "_done_count"}, done_n[s], 1);
    check({pfx, "_busy_after"}, int'(s == 0 ? busy_a : busy_b), 0);
    check({pfx, "_queue_left"}, (s == 0) ? q_a.size() : q_b.size(), 0);
  endtask

  initial begin
    rst = 1'b1; hc = '0; vc = '0; valid = 1'b0; pix = 1'b0; cap_a = 1'b0; cap_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", int'(we_a), 0);
    check("rst_addr", int'(addr_a), 0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_done", int'(done_a), 0);
    check("rst_short", int'(short_a), 0);
    check("rst_busy_b", int'(busy_b), 0);
    rst = 1'b0;

    // Plain full raster.
    reset_stats(0);
    run_frame(0, 0, 0, -1);
    frame_checks(0, 8560);
    check("a_addr_h5_v2", addr52[0], 165);
    check("a_short_full", int'(short_a), 0);

    // Ten in-window pixels invalid: short frame.
    reset_stats(0);
    run_frame(0, 10, 0, -1);
    check("a_short_write_count", wr_n[0], 8550);
    check("a_short_done_count", done_n[0], 1);
    repeat (5) drive(0, 0, 0, 0, 0, 0);
    check("a_short_hold", int'(short_a), 1);

    // Abort by reset at v=50.
    reset_stats(0);
    run_frame(0, 0, 0, 50);
    @(posedge clk);
    #1;
    rst = 1'b1; valid = 1'b0;
    #1;
    check("abort_we", int'(we_a), 0);
    check("abort_addr", int'(addr_a), 0);
    check("abort_pixel", int'(pix_a), 0);
    check("abort_busy", int'(busy_a), 0);
    check("abort_done", int'(done_a), 0);
    check("abort_short", int'(short_a), 0);
    q_a.delete();
    dq_a.delete();
    cap_active = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int h = 0; h < 20; h++) drive(0, h, 51, 1, 1, 0);
    check("abort_no_done", done_n[0], 0);

    // Recapture after abort, with out-of-window pixels and a second origin.
    reset_stats(0);
    run_frame(0, 0, 1, -1);
    frame_checks(0, 8561);
    check("a_extra_short", int'(short_a), 0);

    // Offset origin instance.
    reset_stats(1);
    run_frame(1, 0, 0, -1);
    frame_checks(1, 8560);
    check("b_addr_h5_v2", addr52[1], 165);
    check("b_short", int'(short_b), 0);
    check("a_idle_done_count", done_n[0], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
